// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, the canonical NOP and the
// fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// hands a registered {instruction, pc, valid} bundle to decode.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [ILEN-1:0] NOP_INSTR = INSTR_NOP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_reg_q, pc_reg_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [ILEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic            discard_q, discard_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  assign imem_req    = (state_q == FETCH_REQ) && !redirect_valid && !reset;
  assign imem_addr   = pc_reg_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign valid       = valid_q;

  always_comb begin
    state_d      = state_q;
    pc_reg_d     = pc_reg_q;
    fetch_pc_d   = fetch_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    discard_d    = discard_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;

    // Decode took the current instruction; a load below overrides this.
    if (valid_q && !stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    unique case (state_q)
      FETCH_REQ: begin
        if (imem_req && imem_ready) begin
          fetch_pc_d = pc_reg_q;
          pc_reg_d   = pc_reg_q + 32'd4;
          state_d    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH_REQ;
          if (discard_q) begin
            discard_d = 1'b0;
          end else if (!valid_q || !stall) begin
            instr_d = imem_rdata;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = fetch_pc_q;
            state_d      = FETCH_HOLD;
          end
        end
      end
      FETCH_HOLD: begin
        if (!stall) begin
          instr_d = hold_instr_q;
          pc_d    = hold_pc_q;
          valid_d = 1'b1;
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase

    // A redirect squashes whatever the FSM decided above, including any
    // load into the output slot or hold buffer.
    if (redirect_valid) begin
      pc_reg_d     = redirect_pc & ~32'd3;
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
      pc_d         = pc_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      if (state_q == FETCH_WAIT && !imem_rvalid) begin
        discard_d = 1'b1;
        state_d   = FETCH_WAIT;
      end else begin
        discard_d = 1'b0;
        state_d   = FETCH_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_REQ;
      pc_reg_q     <= RESET_PC;
      fetch_pc_q   <= '0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      discard_q    <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_reg_q     <= pc_reg_d;
      fetch_pc_q   <= fetch_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      discard_q    <= discard_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

  // Memory may only answer the single outstanding request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rvalid && (state_q != FETCH_WAIT)));
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-deep memory model and a queue of
// expected {instruction, pc} bundles filled as read data is returned.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;

  int          errorCount = 0;
  int          checkCount = 0;

  expect_t     expQ[$];
  expect_t     lastShown;
  logic [31:0] addrLog[$];
  bit          memBusy = 0;
  bit          memSquash = 0;
  int          memCount = 0;
  int          rspDelay = 1;
  logic [31:0] memAddr = '0;
  logic        sawReq;
  logic [31:0] sawAddr;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc            (pc),
    .valid         (valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: memory responds, the request is sampled before the edge,
  // and the output bundle is scored after the edge.
  task automatic applyStimulus();
    bit      holdNow;
    expect_t e;
    imem_rvalid = 1'b0;
    if (memBusy) begin
      memCount--;
      if (memCount == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memAddr ^ KEY;
        memBusy     = 0;
        if (!memSquash && !redirect_valid && !reset) begin
          e.instr = memAddr ^ KEY;
          e.pc    = memAddr;
          expQ.push_back(e);
        end
        memSquash = 0;
      end
    end
    if (reset) begin
      memBusy   = 0;
      memSquash = 0;
      expQ.delete();
    end else if (redirect_valid) begin
      expQ.delete();
      if (memBusy) memSquash = 1;
    end
    #1;
    sawReq  = imem_req;
    sawAddr = imem_addr;
    if (reset) checkOutput("req_in_reset", {31'b0, imem_req}, 32'd0);
    if (imem_rvalid || memBusy) checkOutput("req_in_wait", {31'b0, imem_req}, 32'd0);
    if (imem_req && imem_ready) begin
      memBusy  = 1;
      memCount = rspDelay;
      memAddr  = imem_addr;
      addrLog.push_back(imem_addr);
    end
    holdNow = valid && stall && !redirect_valid && !reset;
    @(posedge clk);
    @(negedge clk);
    if (holdNow) begin
      checkOutput("held_valid", {31'b0, valid}, 32'd1);
      checkOutput("held_instr", instruction, lastShown.instr);
      checkOutput("held_pc", pc, lastShown.pc);
    end else if (valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_valid", {31'b0, valid}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_instr", instruction, e.instr);
        checkOutput("out_pc", pc, e.pc);
        lastShown = e;
      end
    end
    if (valid !== 1'b1) checkOutput("nop_when_invalid", instruction, NOP);
  endtask

  task automatic applyReset();
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_ready     = 1'b1;
    rspDelay       = 1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    addrLog.delete();
    checkOutput("rst_valid", {31'b0, valid}, 32'd0);
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'd0);
  endtask

  initial begin
    @(negedge clk);

    // Straight-line fetch, one instruction every two cycles.
    applyReset();
    for (int i = 1; i <= 6; i++) begin
      applyStimulus();
      checkOutput("s1_valid", {31'b0, valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    checkOutput("s1_nreq", addrLog.size(), 32'd3);
    checkOutput("s1_addr0", addrLog[0], 32'd0);
    checkOutput("s1_addr1", addrLog[1], 32'd4);
    checkOutput("s1_addr2", addrLog[2], 32'd8);
    checkOutput("s1_drain", expQ.size(), 32'd0);

    // Stall with a second word arriving: it parks in the hold buffer.
    applyReset();
    repeat (4) applyStimulus();
    checkOutput("s2_pc4", pc, 32'd4);
    stall = 1'b1;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("s2_noreq_hold_a", {31'b0, sawReq}, 32'd0);
    applyStimulus();
    checkOutput("s2_noreq_hold_b", {31'b0, sawReq}, 32'd0);
    checkOutput("s2_still_pc4", pc, 32'd4);
    stall = 1'b0;
    applyStimulus();
    checkOutput("s2_noreq_release", {31'b0, sawReq}, 32'd0);
    checkOutput("s2_pc8", pc, 32'd8);
    checkOutput("s2_valid8", {31'b0, valid}, 32'd1);
    checkOutput("s2_nreq", addrLog.size(), 32'd3);
    applyStimulus();
    checkOutput("s2_req12", {31'b0, sawReq}, 32'd1);
    checkOutput("s2_addr12", sawAddr, 32'd12);

    // Redirect while waiting; the late word must be dropped.
    applyReset();
    rspDelay = 3;
    applyStimulus();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    applyStimulus();
    redirect_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("s3_dropped", {31'b0, valid}, 32'd0);
    rspDelay = 1;
    applyStimulus();
    checkOutput("s3_req", {31'b0, sawReq}, 32'd1);
    checkOutput("s3_addr", sawAddr, 32'h0000_0100);
    applyStimulus();
    checkOutput("s3_pc", pc, 32'h0000_0100);
    checkOutput("s3_valid", {31'b0, valid}, 32'd1);

    // Redirect in the same cycle as read data: no lingering discard.
    applyReset();
    applyStimulus();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("s4_dropped", {31'b0, valid}, 32'd0);
    applyStimulus();
    checkOutput("s4_addr", sawAddr, 32'h0000_0200);
    applyStimulus();
    checkOutput("s4_valid", {31'b0, valid}, 32'd1);
    checkOutput("s4_instr", instruction, 32'h0000_0200 ^ KEY);

    // PC wraps from the top of the address space.
    applyReset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    applyStimulus();
    checkOutput("s5_req_suppressed", {31'b0, sawReq}, 32'd0);
    redirect_valid = 1'b0;
    applyStimulus();
    checkOutput("s5_addr_top", sawAddr, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("s5_pc_top", pc, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("s5_addr_wrap", sawAddr, 32'd0);

    // Reset in the middle of an outstanding fetch.
    applyReset();
    repeat (4) applyStimulus();
    checkOutput("s6_pc4", pc, 32'd4);
    stall    = 1'b1;
    rspDelay = 2;
    applyStimulus();
    reset = 1'b1;
    stall = 1'b0;
    applyStimulus();
    checkOutput("s6_valid", {31'b0, valid}, 32'd0);
    checkOutput("s6_pc", pc, 32'd0);
    checkOutput("s6_instr", instruction, NOP);
    reset = 1'b0;
    applyStimulus();
    checkOutput("s6_req", {31'b0, sawReq}, 32'd1);
    checkOutput("s6_addr", sawAddr, 32'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("s6_first_pc", pc, 32'd0);
    checkOutput("s6_first_valid", {31'b0, valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage, directly upstream of decode.
- Owns the program counter.
- Issues word fetches to instruction memory over a req/ready + rvalid handshake, one request outstanding at a time.
- Presents a registered {instruction, pc, valid} bundle to decode and honours decode stall.
- Accepts branch/jump redirects from later stages, squashing in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, value driven on instruction whenever the slot is invalid (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  decode cannot accept; output bundle must hold
- redirect_valid  input  1  redirect request from a later stage
- redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0
- imem_req  output  1  fetch request; combinational, equals (state==REQ) && !redirect_valid && !reset
- imem_addr  output  32  fetch address, equal to pc_reg
- imem_ready  input  1  memory accepts the request this cycle
- imem_rvalid  input  1  read data valid; at most one per accepted request, earliest the cycle after acceptance
- imem_rdata  input  32  fetched instruction word
- instruction  output  32  instruction to decode (registered)
- pc  output  32  address of instruction (registered)
- valid  output  1  instruction/pc hold a live instruction (registered)

Behaviour:
- Reset (sync, overrides everything):
  - pc_reg=RESET_PC, state=REQ, discard=0.
  - instruction=NOP_INSTR, pc=0, valid=0.
  - hold_instr=NOP_INSTR, hold_pc=0.
  - imem_req=0 while reset is asserted.
- Internal state: pc_reg, fetch_pc, hold_instr, hold_pc, discard flag, and FSM {REQ, WAIT, HOLD}.
- REQ: when imem_req && imem_ready:
  - fetch_pc<=pc_reg; pc_reg<=pc_reg+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
  - Go to WAIT.
  - Without ready: remain in REQ, holding the address.
- WAIT, on imem_rvalid:
  - discard=1: drop the data, clear discard, go to REQ.
  - Else, output slot free (valid==0 or stall==0): instruction<=imem_rdata, pc<=fetch_pc, valid<=1, go to REQ.
  - Else (valid && stall): hold_instr<=imem_rdata, hold_pc<=fetch_pc, go to HOLD.
- HOLD: when stall==0, load the output from hold_*, set valid<=1, go to REQ. No request is issued in HOLD.
- Consumption: valid && !stall with no new load this cycle gives valid<=0 and instruction<=NOP_INSTR; pc holds.
- Stall: while stall && valid, instruction/pc/valid are frozen. stall with valid==0 has no effect.
- Redirect (priority over all of the above except reset):
  - pc_reg<=redirect_pc & ~3; valid<=0; instruction<=NOP_INSTR.
  - REQ: imem_req is suppressed that cycle, so no acceptance occurs; stay in REQ.
  - WAIT && !imem_rvalid: discard<=1, stay in WAIT.
  - WAIT && imem_rvalid same cycle: drop the data, go to REQ, discard stays 0.
  - HOLD: drop the buffered instruction, go to REQ.
  - Redirect during stall: redirect still applies and valid clears.
- A second redirect while discard=1 updates pc_reg only; discard stays 1.
- Latency: request accepted at cycle N, rvalid at N+1, valid at N+2. Peak throughput is one instruction per 2 cycles; this is accepted for this revision.
- Never more than one outstanding request. imem_rvalid outside WAIT is ignored; assert this in simulation.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSTR constant.
  - fetch FSM state encoding.
  - XLEN=32 and the instruction-width constant.
- No sub-module. The block is PC register, a 3-state FSM, and a one-entry hold buffer; keep it flat, roughly 150 lines.

Test Plan:
- Reset then imem_ready=1, rvalid one cycle after each accept with rdata=addr^32'hA5A5_0000 → addresses 0,4,8 requested; valid pulses with pc=0,4,8 and matching instruction; imem_req never high in WAIT.
- stall=1 while valid with pc=4 and next rvalid arrives → pc=4 held; HOLD entered; after stall drops, pc=8 presented next cycle; no address 12 request until then.
- Redirect to 32'h0000_0103 while in WAIT, rvalid two cycles later → returned word dropped; valid stays 0; next imem_addr=32'h0000_0100.
- redirect_valid and imem_rvalid in the same cycle → data dropped; valid=0; next request at redirect target, no extra discard.
- pc_reg=32'hFFFF_FFFC accepted → next imem_addr=0; output pc=32'hFFFF_FFFC.
- reset asserted mid-WAIT with rvalid arriving next cycle → outputs return to reset values; first request at RESET_PC; the late rvalid triggers the out-of-WAIT assertion only if not in WAIT (bench masks the cycle when memory is also reset).
